// File: rtl/data_unpack.sv
// Width down-converter: one I_WIDTH word in, N = I_WIDTH/O_WIDTH beats out.
// Registered outputs, zero-bubble reload on the last beat of a word.
module data_unpack #(
    parameter int I_WIDTH   = 32,
    parameter int O_WIDTH   = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [I_WIDTH-1:0] in_data_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic [O_WIDTH-1:0] out_data_o,
    output logic               out_valid_o,
    output logic               out_last_o,
    input  logic               out_ready_i
);

    localparam int N  = I_WIDTH / O_WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    // Reject widths that do not split into at least two whole beats.
    if (((I_WIDTH % O_WIDTH) != 0) || (N < 2)) begin : g_bad_params
        $error("data_unpack: I_WIDTH must be a multiple of O_WIDTH with N >= 2");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state;
    logic [I_WIDTH-1:0] sr;
    logic [I_WIDTH-1:0] sr_shift;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_inc;
    logic               in_fire;
    logic               out_fire;

    // Beat that leaves first from a given word image.
    function automatic logic [O_WIDTH-1:0] head(input logic [I_WIDTH-1:0] w);
        if (MSB_FIRST) begin
            return w[I_WIDTH-1 -: O_WIDTH];
        end
        return w[O_WIDTH-1:0];
    endfunction

    // A new word may enter when idle or when the last beat is leaving now.
    assign in_ready_o = ~out_valid_o | (out_ready_i & out_last_o);
    assign in_fire    = in_valid_i & in_ready_o;
    assign out_fire   = out_valid_o & out_ready_i;

    // Next word image with the consumed beat shifted out, and next beat index.
    always_comb begin
        sr_shift = sr;
        cnt_inc  = cnt + CW'(1);
        if (MSB_FIRST) begin
            sr_shift = sr << O_WIDTH;
        end else begin
            sr_shift = sr >> O_WIDTH;
        end
    end

    // Control FSM with registered beat, valid and last.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            sr          <= '0;
            cnt         <= '0;
            out_data_o  <= '0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_fire) begin
                        state       <= BUSY;
                        sr          <= in_data_i;
                        cnt         <= '0;
                        out_data_o  <= head(in_data_i);
                        out_valid_o <= 1'b1;
                        out_last_o  <= 1'b0;
                    end
                end
                BUSY: begin
                    if (out_fire) begin
                        if (!out_last_o) begin
                            sr         <= sr_shift;
                            cnt        <= cnt_inc;
                            out_data_o <= head(sr_shift);
                            out_last_o <= (cnt_inc == LAST_CNT);
                        end else if (in_fire) begin
                            sr         <= in_data_i;
                            cnt        <= '0;
                            out_data_o <= head(in_data_i);
                            out_last_o <= 1'b0;
                        end else begin
                            state       <= IDLE;
                            cnt         <= '0;
                            out_valid_o <= 1'b0;
                            out_last_o  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_o <= 1'b0;
                    out_last_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_unpack.sv
// Bench for data_unpack: three instances (32/8 MSB-first, 32/8 LSB-first,
// 16/8 MSB-first) checked every cycle against a queue-of-beats model.
module tb_data_unpack;

    logic        clk;
    logic [2:0]  rstn;
    logic [2:0]  iv;
    logic [2:0]  rdy;
    logic [31:0] id [3];
    wire  [2:0]  ir;
    wire  [2:0]  ov;
    wire  [2:0]  ol;
    wire  [7:0]  od [3];

    int vectors = 0;
    int errors  = 0;

    typedef logic [8:0] beat_q_t [$];
    beat_q_t exq [3];

    data_unpack #(.I_WIDTH(32), .O_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk_i(clk), .rst_n_i(rstn[0]),
        .in_data_i(id[0]), .in_valid_i(iv[0]), .in_ready_o(ir[0]),
        .out_data_o(od[0]), .out_valid_o(ov[0]), .out_last_o(ol[0]),
        .out_ready_i(rdy[0])
    );

    data_unpack #(.I_WIDTH(32), .O_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk_i(clk), .rst_n_i(rstn[1]),
        .in_data_i(id[1]), .in_valid_i(iv[1]), .in_ready_o(ir[1]),
        .out_data_o(od[1]), .out_valid_o(ov[1]), .out_last_o(ol[1]),
        .out_ready_i(rdy[1])
    );

    data_unpack #(.I_WIDTH(16), .O_WIDTH(8), .MSB_FIRST(1'b1)) u_n2 (
        .clk_i(clk), .rst_n_i(rstn[2]),
        .in_data_i(id[2][15:0]), .in_valid_i(iv[2]), .in_ready_o(ir[2]),
        .out_data_o(od[2]), .out_valid_o(ov[2]), .out_last_o(ol[2]),
        .out_ready_i(rdy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int k, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL inst%0d %s: got %h want %h at %0t", k, nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // j-th emitted byte of a word of n bytes.
    function automatic logic [7:0] beat(input logic [31:0] w, input int j,
                                        input int n, input bit msb);
        int p;
        p = msb ? (n - 1 - j) : j;
        return 8'(w >> (8 * p));
    endfunction

    // Model: each accepted word becomes n queued beats; outputs must show the head.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rstn[k]) begin
                exq[k].delete();
            end else begin
                int  n;
                bit  msb;
                logic [31:0] w;
                chk(k, "out_valid", {31'b0, ov[k]}, {31'b0, exq[k].size() != 0});
                chk(k, "in_ready", {31'b0, ir[k]},
                    {31'b0, (exq[k].size() == 0) || (rdy[k] && exq[k].size() == 1)});
                if (ov[k] && exq[k].size() != 0) begin
                    chk(k, "out_data", {24'b0, od[k]}, {24'b0, exq[k][0][8:1]});
                    chk(k, "out_last", {31'b0, ol[k]}, {31'b0, exq[k][0][0]});
                    if (rdy[k]) void'(exq[k].pop_front());
                end
                if (iv[k] && ir[k]) begin
                    n   = (k == 2) ? 2 : 4;
                    msb = (k != 1);
                    w   = (k == 2) ? {16'b0, id[k][15:0]} : id[k];
                    for (int j = 0; j < n; j++)
                        exq[k].push_back({beat(w, j, n, msb), j == n - 1});
                end
            end
        end
    end

    // Random words with random gaps and ~50% downstream stalls.
    task automatic run_random(input int k, input int words, input bit toggle);
        int sent = 0;
        int cyc  = 0;
        bit pend = 0;
        bit fired;
        while ((sent < words || pend || exq[k].size() != 0) && cyc < 20000) begin
            @(negedge clk);
            fired = iv[k] & ir[k];
            step();
            cyc++;
            if (fired) begin
                pend = 0;
                sent++;
            end
            if (toggle) begin
                iv[k] = (sent < words) ? ~iv[k] : 1'b0;
                id[k] = $urandom;
            end else if (!pend && sent < words && $urandom_range(3) != 0) begin
                id[k] = $urandom;
                iv[k] = 1'b1;
                pend  = 1;
            end else if (!pend) begin
                iv[k] = 1'b0;
                id[k] = $urandom;
            end
            rdy[k] = (sent < words) ? 1'($urandom_range(1)) : 1'b1;
        end
        iv[k] = 1'b0;
        chk(k, "no_timeout", {31'b0, cyc < 20000}, 32'd1);
        chk(k, "words_sent", sent, words);
        step();
        chk(k, "drained", exq[k].size(), 0);
    endtask

    task automatic word_beats(input int k, input logic [31:0] w,
                              input logic [7:0] e [4], input string nm);
        step();
        id[k] = w;
        iv[k] = 1'b1;
        chk(k, {nm, "_ready_idle"}, {31'b0, ir[k]}, 32'd1);
        step();
        iv[k] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk(k, {nm, "_data"}, {24'b0, od[k]}, {24'b0, e[i]});
            chk(k, {nm, "_last"}, {31'b0, ol[k]}, {31'b0, i == 3});
            chk(k, {nm, "_ready"}, {31'b0, ir[k]}, {31'b0, i == 3});
            step();
        end
        chk(k, {nm, "_idle"}, {31'b0, ov[k]}, 32'd0);
    endtask

    task automatic proc_msb();
        logic [7:0] e [4];
        logic [7:0] e8 [8];
        rdy[0] = 1'b1;
        e = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        word_beats(0, 32'hA1B2C3D4, e, "t1");
        e8 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        step();
        id[0] = 32'h11223344;
        iv[0] = 1'b1;
        step();
        id[0] = 32'h55667788;
        for (int i = 0; i < 8; i++) begin
            chk(0, "t3_data", {24'b0, od[0]}, {24'b0, e8[i]});
            chk(0, "t3_valid", {31'b0, ov[0]}, 32'd1);
            chk(0, "t3_last", {31'b0, ol[0]}, {31'b0, (i % 4) == 3});
            step();
            if (i == 3) iv[0] = 1'b0;
        end
        chk(0, "t3_idle", {31'b0, ov[0]}, 32'd0);
        step();
        id[0] = 32'hDEADBEEF;
        iv[0] = 1'b1;
        step();
        iv[0] = 1'b0;
        chk(0, "t5_first", {24'b0, od[0]}, 32'h0000_00DE);
        step();
        step();
        chk(0, "t5_third", {24'b0, od[0]}, 32'h0000_00BE);
        rstn[0] = 1'b0;
        #1;
        chk(0, "t5_rst_valid", {31'b0, ov[0]}, 32'd0);
        chk(0, "t5_rst_ready", {31'b0, ir[0]}, 32'd1);
        chk(0, "t5_rst_last", {31'b0, ol[0]}, 32'd0);
        chk(0, "t5_rst_data", {24'b0, od[0]}, 32'd0);
        step();
        rstn[0] = 1'b1;
        e = '{8'h01, 8'h02, 8'h03, 8'h04};
        word_beats(0, 32'h01020304, e, "t5");
        run_random(0, 100, 1'b0);
    endtask

    task automatic proc_lsb();
        logic [7:0] e [4];
        rdy[1] = 1'b1;
        e = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        word_beats(1, 32'hA1B2C3D4, e, "t2");
        run_random(1, 100, 1'b0);
    endtask

    task automatic proc_n2();
        rdy[2] = 1'b1;
        run_random(2, 60, 1'b1);
    endtask

    initial begin
        rstn = 3'b000;
        iv   = 3'b000;
        rdy  = 3'b000;
        for (int k = 0; k < 3; k++) id[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk(k, "rst_valid", {31'b0, ov[k]}, 32'd0);
            chk(k, "rst_last", {31'b0, ol[k]}, 32'd0);
            chk(k, "rst_data", {24'b0, od[k]}, 32'd0);
            chk(k, "rst_ready", {31'b0, ir[k]}, 32'd1);
        end
        rstn = 3'b111;
        fork
            proc_msb();
            proc_lsb();
            proc_n2();
        join
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running want done");
        $fatal(1, "watchdog");
    end

endmodule
